// File: rtl/window_buffer_gen_pkg.sv
// Shared constants and helpers for the KxK window generator.
// Border policies and the flat-vector offset of window element (i,j).
package window_buffer_pkg;

  localparam int BORDER_ZERO = 0;
  localparam int BORDER_REPL = 1;

  // Bit offset of element (i,j) in a flattened k x k window of w-bit words.
  function automatic int win_idx(input int i, input int j, input int k, input int w);
    return (i * k + j) * w;
  endfunction

endpackage

// File: rtl/window_buffer_gen_line_mem.sv
// One line of pixel storage: asynchronous read, synchronous write.
// Read and write share the address so the read returns the pre-write word.
module line_mem #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 640,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/window_buffer_gen.sv
// Streaming causal KxK neighbourhood generator with internal line rotation.
// Handshake: a pixel is taken when in_valid & ou_pix_ready; a window is consumed when ou_valid & in_win_ready.
module window_buffer_gen
  import window_buffer_pkg::*;
#(
  parameter  int DATA_W      = 32,
  parameter  int WIDTH       = 640,
  parameter  int HEIGHT      = 480,
  parameter  int KSIZE       = 3,
  parameter  int BORDER_MODE = 0,
  localparam int COL_W       = $clog2(WIDTH),
  localparam int ROW_W       = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  input  logic                            in_sof,
  output logic                            ou_pix_ready,
  input  logic                            in_win_ready,
  output logic [KSIZE*KSIZE*DATA_W-1:0]   ou_window,
  output logic                            ou_valid,
  output logic [COL_W-1:0]                ou_col,
  output logic [ROW_W-1:0]                ou_row,
  output logic                            ou_eol,
  output logic                            ou_eof
);

  localparam int NSLOT  = KSIZE - 1;
  localparam int SEL_W  = (NSLOT > 1) ? $clog2(NSLOT) : 1;
  localparam int FILL_W = $clog2(KSIZE);
  localparam int WIN_W  = KSIZE * KSIZE * DATA_W;
  localparam bit REPL   = (BORDER_MODE == BORDER_REPL);

  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [FILL_W-1:0] r_fill;
  logic [SEL_W-1:0]  r_wr_sel;
  logic              r_sync;
  logic              r_valid;
  logic [WIN_W-1:0]  r_win;
  logic [COL_W-1:0]  r_out_col;
  logic [ROW_W-1:0]  r_out_row;
  logic              r_eol;
  logic              r_eof;

  logic              w_accept;
  logic              w_take;
  logic [COL_W-1:0]  w_pos_col;
  logic [ROW_W-1:0]  w_pos_row;
  logic [FILL_W-1:0] w_pos_fill;
  logic              w_last_col;
  logic              w_last_row;
  logic [DATA_W-1:0] w_rd      [NSLOT];
  logic [DATA_W-1:0] w_raw     [KSIZE];
  logic [DATA_W-1:0] w_col_new [KSIZE];
  logic [DATA_W-1:0] w_top_val;
  logic [WIN_W-1:0]  w_win_nxt;

  assign ou_pix_ready = !r_valid || in_win_ready;
  assign w_accept     = in_valid && ou_pix_ready;
  // Accepted pixels only count once a frame start has been seen.
  assign w_take       = w_accept && (r_sync || in_sof);

  // Position of the pixel being taken; in_sof restarts the frame at (0,0).
  assign w_pos_col  = in_sof ? '0 : r_col;
  assign w_pos_row  = in_sof ? '0 : r_row;
  assign w_pos_fill = in_sof ? '0 : r_fill;
  assign w_last_col = (w_pos_col == COL_W'(WIDTH - 1));
  assign w_last_row = (w_pos_row == ROW_W'(HEIGHT - 1));

  for (genvar g = 0; g < NSLOT; g++) begin : g_line
    line_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (WIDTH)
    ) u_line_mem (
      .clk     (clk),
      .i_we    (w_take && (r_wr_sel == SEL_W'(g))),
      .i_addr  (w_pos_col),
      .i_wdata (in_data),
      .o_rdata (w_rd[g])
    );
  end

  // New column: slot (wr_sel+i) mod NSLOT holds window row i; rows above the fill are out of frame.
  always_comb begin
    for (int i = 0; i < KSIZE; i++) begin
      w_raw[i]     = '0;
      w_col_new[i] = '0;
    end
    w_top_val = '0;
    for (int i = 0; i < NSLOT; i++) begin
      for (int s = 0; s < NSLOT; s++) begin
        if (((s - i + NSLOT) % NSLOT) == int'(r_wr_sel)) w_raw[i] = w_rd[s];
      end
    end
    w_raw[KSIZE-1] = in_data;
    for (int t = 0; t < KSIZE; t++) begin
      if (t == NSLOT - int'(w_pos_fill)) w_top_val = w_raw[t];
    end
    for (int i = 0; i < KSIZE; i++) begin
      if (i < NSLOT - int'(w_pos_fill)) w_col_new[i] = REPL ? w_top_val : '0;
      else                              w_col_new[i] = w_raw[i];
    end
  end

  // Shift left, except at column 0 where older columns are refilled so the previous line never leaks in.
  always_comb begin
    w_win_nxt = r_win;
    for (int i = 0; i < KSIZE; i++) begin
      for (int j = 0; j < KSIZE; j++) begin
        if (j == KSIZE - 1)
          w_win_nxt[win_idx(i, j, KSIZE, DATA_W) +: DATA_W] = w_col_new[i];
        else if (w_pos_col == '0)
          w_win_nxt[win_idx(i, j, KSIZE, DATA_W) +: DATA_W] = REPL ? w_col_new[i] : '0;
        else
          w_win_nxt[win_idx(i, j, KSIZE, DATA_W) +: DATA_W] =
            r_win[win_idx(i, j + 1, KSIZE, DATA_W) +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col     <= '0;
      r_row     <= '0;
      r_fill    <= '0;
      r_wr_sel  <= '0;
      r_sync    <= 1'b0;
      r_valid   <= 1'b0;
      r_win     <= '0;
      r_out_col <= '0;
      r_out_row <= '0;
      r_eol     <= 1'b0;
      r_eof     <= 1'b0;
    end else begin
      if (w_take) begin
        r_sync    <= 1'b1;
        r_win     <= w_win_nxt;
        r_out_col <= w_pos_col;
        r_out_row <= w_pos_row;
        r_eol     <= w_last_col;
        r_eof     <= w_last_col && w_last_row;
        if (w_last_col) begin
          r_col    <= '0;
          r_wr_sel <= (r_wr_sel == SEL_W'(NSLOT - 1)) ? '0 : r_wr_sel + 1'b1;
          if (w_last_row) begin
            r_row  <= '0;
            r_fill <= '0;
          end else begin
            r_row  <= w_pos_row + 1'b1;
            r_fill <= (w_pos_fill == FILL_W'(NSLOT)) ? w_pos_fill : w_pos_fill + 1'b1;
          end
        end else begin
          r_col  <= w_pos_col + 1'b1;
          r_row  <= w_pos_row;
          r_fill <= w_pos_fill;
        end
      end
      if (w_take)            r_valid <= 1'b1;
      else if (in_win_ready) r_valid <= 1'b0;
    end
  end

  assign ou_window = r_win;
  assign ou_valid  = r_valid;
  assign ou_col    = r_out_col;
  assign ou_row    = r_out_row;
  assign ou_eol    = r_eol;
  assign ou_eof    = r_eof;

endmodule
